ym2149_bus_responder: RTL and testbench
=======================================

# ym2149_bus_responder

- PSG-side responder for the YM2149/AY bus, i.e. the receiving end of the BDIR/BC1 strobes and data bus produced by the Z80 port decoder.
- Synchronises the bus into `cpu_clock`, decodes latch/write/read phases and holds the 16-entry register file with AY bit masks.
- Handles TurboSound chip selection internally and drives read-back data.
- Downstream tone/noise/envelope generators consume its register contents and strobes.

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth on bdir/bc1/da_in (2 or 3).

Ports:
- cpu_clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low.
- bdir  input  1  bus direction strobe from port decoder.
- bc1  input  1  bus control 1 from port decoder (BC2 tied high).
- da_in  input  8  CPU data bus toward PSG.
- da_out  output  8  register read-back data.
- da_oe  output  1  read-back drive enable.
- active_chip  output  1  TurboSound selected chip (0/1).
- addr_valid  output  1  latched address has upper nibble zero.
- wr_stb  output  1  one-cycle pulse on committed register write.
- wr_chip  output  1  chip written by the current wr_stb.
- wr_addr  output  4  register index of the current wr_stb.
- wr_data  output  8  masked data of the current wr_stb.
- env_restart  output  1  one-cycle pulse on a committed write to R13.
- regs_flat  output  256  both banks, {bank1 R15..R0, bank0 R15..R0}, masked.

## Operation
- Modes from synced {bdir,bc1}: 00 INACTIVE, 01 READ, 10 WRITE, 11 LATCH.
- mode_q holds the previous synced mode. A mode is *stable* when synced == mode_q.
- FSM states: IDLE, LATCH, WRITE, READ. A state is entered only on a stable mode and exited when the synced mode differs.
- While in LATCH or WRITE, da_in (synced) is captured every cycle; the last captured value is committed on exit.

LATCH exit:
- If captured[7:3] == 5'b11111: TurboSound command. active_chip <= ~captured[0] (0xFF → chip 0, 0xFE → chip 1). The latched address is unchanged.
- Otherwise: addr <= captured[3:0]; addr_valid <= (captured[7:4] == 0).

WRITE exit:
- If addr_valid: the register in bank active_chip at addr <= captured & mask.
- wr_stb pulses; env_restart also pulses if addr == 13.
- If not addr_valid: write is ignored, no strobe.

Register masks:
- R1, R3, R5: 0x0F.
- R6, R8, R9, R10: 0x1F.
- R13: 0x0F.
- All other registers: 0xFF.

READ:
- da_out = masked register [active_chip][addr].
- da_oe = 1 while in READ and addr_valid.

Other:
- Direct LATCH↔WRITE↔READ transitions without an intervening INACTIVE are legal; the exit action occurs, then the new state is entered on its stable cycle.
- A mode seen for only one synced cycle (glitch) is ignored.

## Timing
- Pin change → synced: SYNC_STAGES edges. Stable detection +1 edge. Exit detection likewise takes SYNC_STAGES+1 edges after the pins leave the mode.
- wr_stb, env_restart: high exactly one cycle, on the edge after exit detection. Register contents, wr_addr, wr_data and wr_chip are valid in that same cycle.
- da_oe rises on the stable-READ edge and falls on the first edge where the synced mode ≠ 01. da_out is registered, with the same latency.
- Reset values: all registers 0; addr 0; addr_valid 1; active_chip 0; da_out 0; da_oe 0; wr_stb 0; wr_chip 0; wr_addr 0; wr_data 0; env_restart 0; FSM IDLE.
- Reset asserted mid-cycle aborts the operation: nothing is committed and no strobe is produced.
- Simultaneous exit and entry: the exit commit happens on the detection edge, and the new state's first capture happens on the same edge.

## Configuration
- TURBOSOUND_EN defined: two banks; 0xF8–0xFF latch values are TurboSound commands as above.
- TURBOSOUND_EN undefined:
  - Single bank; active_chip and wr_chip are tied to 0, and bank 1 of regs_flat reads 0.
  - 0xF8–0xFF latches are ordinary latches, so addr_valid = 0 (deselected).

## Test plan
- Reset, then latch 0x07, write 0xAA, read back → wr_stb once with wr_addr=7, wr_data=0xAA; da_out=0xAA with da_oe=1.
- Latch 0x01, write 0xFF → stored value 0x0F. Latch 0x0D, write 0x3E → R13=0x0E, env_restart pulses exactly once.
- Latch 0xFE, latch 0x00, write 0x55; then latch 0xFF, read R0 → bank1 R0=0x55, read returns bank0 R0=0x00, active_chip=0.
- Latch 0x17, write 0x12, read → addr_valid=0, no wr_stb, da_oe stays 0.
- 1-cycle bdir pulse between 2-cycle INACTIVE periods → no state change, no strobe.
- Reset asserted during a WRITE phase → no wr_stb; all registers 0; FSM IDLE.

Source files
------------

// File: rtl/ym2149_bus_responder.sv
// YM2149/AY PSG-side bus responder: synchronises BDIR/BC1/DA, decodes latch/write/read
// phases and holds the masked register file. Define TURBOSOUND_EN for the two-chip bank.
module ym2149_bus_responder #(
   parameter int SYNC_STAGES = 2
) (
   input  logic         cpu_clock,
   input  logic         reset,
   input  logic         bdir,
   input  logic         bc1,
   input  logic [7:0]   da_in,
   output logic [7:0]   da_out,
   output logic         da_oe,
   output logic         active_chip,
   output logic         addr_valid,
   output logic         wr_stb,
   output logic         wr_chip,
   output logic [3:0]   wr_addr,
   output logic [7:0]   wr_data,
   output logic         env_restart,
   output logic [255:0] regs_flat
);
   localparam logic [1:0] MODE_INACTIVE = 2'b00;
   localparam logic [1:0] MODE_READ     = 2'b01;
   localparam logic [1:0] MODE_WRITE    = 2'b10;
   localparam logic [1:0] MODE_LATCH    = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LATCH = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_READ  = 2'd3;

`ifdef TURBOSOUND_EN
   localparam int NUM_BANKS = 2;
   localparam int IDX_W     = 5;
`else
   localparam int NUM_BANKS = 1;
   localparam int IDX_W     = 4;
`endif

   function automatic logic [7:0] reg_mask(input logic [3:0] a);
      case (a)
         4'd1, 4'd3, 4'd5, 4'd13: return 8'h0F;
         4'd6, 4'd8, 4'd9, 4'd10: return 8'h1F;
         default:                 return 8'hFF;
      endcase
   endfunction

   function automatic logic [1:0] state_mode(input logic [1:0] st);
      case (st)
         ST_LATCH: return MODE_LATCH;
         ST_WRITE: return MODE_WRITE;
         ST_READ:  return MODE_READ;
         default:  return MODE_INACTIVE;
      endcase
   endfunction

   function automatic logic [1:0] mode_state(input logic [1:0] m);
      case (m)
         MODE_LATCH: return ST_LATCH;
         MODE_WRITE: return ST_WRITE;
         MODE_READ:  return ST_READ;
         default:    return ST_IDLE;
      endcase
   endfunction

   logic [9:0]       sync_q [SYNC_STAGES];
   logic [1:0]       mode_s, mode_q;
   logic [7:0]       data_s, cap_q;
   logic [1:0]       state_q, state_d;
   logic             exiting, latch_commit, write_commit, ts_cmd, stable;
   logic [3:0]       addr_q, addr_d;
   logic             addr_valid_q, addr_valid_d;
   logic             bank_q, bank_d;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [7:0]       regs_q [NUM_BANKS*16];
   logic [7:0]       da_out_q;
   logic             da_oe_q, wr_stb_q, wr_chip_q, env_restart_q;
   logic [3:0]       wr_addr_q;
   logic [7:0]       wr_data_q;

   always_ff @(posedge cpu_clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage shift on the same edge without ordering hazards.
         sync_q[0] <= {bdir, bc1, da_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign mode_s = sync_q[SYNC_STAGES-1][9:8];
   assign data_s = sync_q[SYNC_STAGES-1][7:0];
   assign stable = (mode_s == mode_q);

   // A state is left as soon as the synced mode departs, and entered only once a mode is stable.
   always_comb begin
      state_d = state_q;
      exiting = 1'b0;
      if (state_q != ST_IDLE && mode_s != state_mode(state_q)) begin
         exiting = 1'b1;
         state_d = ST_IDLE;
      end
      if ((state_q == ST_IDLE || exiting) && stable) state_d = mode_state(mode_s);
   end

   assign latch_commit = exiting && (state_q == ST_LATCH);
   assign write_commit = exiting && (state_q == ST_WRITE) && addr_valid_q;

`ifdef TURBOSOUND_EN
   assign ts_cmd = (cap_q[7:3] == 5'b11111);
   assign bank_d = (latch_commit && ts_cmd) ? ~cap_q[0] : bank_q;
   assign wr_idx = {bank_q, addr_q};
   assign rd_idx = {bank_d, addr_d};
`else
   assign ts_cmd = 1'b0;
   assign bank_d = 1'b0;
   assign wr_idx = addr_q;
   assign rd_idx = addr_d;
`endif

   always_comb begin
      addr_d       = addr_q;
      addr_valid_d = addr_valid_q;
      if (latch_commit && !ts_cmd) begin
         addr_d       = cap_q[3:0];
         addr_valid_d = (cap_q[7:4] == 4'h0);
      end
   end

   always_ff @(posedge cpu_clock or negedge reset) begin
      if (!reset) begin
         mode_q        <= MODE_INACTIVE;
         state_q       <= ST_IDLE;
         cap_q         <= '0;
         addr_q        <= '0;
         addr_valid_q  <= 1'b1;
         bank_q        <= 1'b0;
         da_out_q      <= '0;
         da_oe_q       <= 1'b0;
         wr_stb_q      <= 1'b0;
         wr_chip_q     <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         env_restart_q <= 1'b0;
         // NOTE: the register file is small and must read back as zero after reset, so it is reset like any flop.
         for (int i = 0; i < NUM_BANKS*16; i++) regs_q[i] <= '0;
      end else begin
         mode_q        <= mode_s;
         state_q       <= state_d;
         addr_q        <= addr_d;
         addr_valid_q  <= addr_valid_d;
         bank_q        <= bank_d;
         wr_stb_q      <= 1'b0;
         env_restart_q <= 1'b0;
         if (state_d == ST_LATCH || state_d == ST_WRITE) cap_q <= data_s;
         if (write_commit) begin
            regs_q[wr_idx] <= cap_q & reg_mask(addr_q);
            wr_stb_q       <= 1'b1;
            wr_chip_q      <= bank_q;
            wr_addr_q      <= addr_q;
            wr_data_q      <= cap_q & reg_mask(addr_q);
            env_restart_q  <= (addr_q == 4'd13);
         end
         da_oe_q  <= (state_d == ST_READ) && addr_valid_d;
         da_out_q <= (state_d == ST_READ) ? regs_q[rd_idx] : 8'h00;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < NUM_BANKS*16; i++) regs_flat[i*8 +: 8] = regs_q[i];
   end

   assign da_out      = da_out_q;
   assign da_oe       = da_oe_q;
   assign active_chip = bank_q;
   assign addr_valid  = addr_valid_q;
   assign wr_stb      = wr_stb_q;
   assign wr_chip     = wr_chip_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign env_restart = env_restart_q;
endmodule

// File: tb/tb_ym2149_bus_responder.sv
// Scoreboard bench for ym2149_bus_responder: directed bus phases push expected strobes/reads,
// a negedge monitor pops and compares whenever the DUT presents wr_stb or raises da_oe.
`timescale 1ns/1ps
module tb_ym2149_bus_responder;
   logic         cpu_clock = 1'b0;
   logic         reset = 1'b0;
   logic         bdir = 1'b0;
   logic         bc1 = 1'b0;
   logic [7:0]   da_in = 8'h00;
   logic [7:0]   da_out;
   logic         da_oe, active_chip, addr_valid, wr_stb, wr_chip, env_restart;
   logic [3:0]   wr_addr;
   logic [7:0]   wr_data;
   logic [255:0] regs_flat;

   ym2149_bus_responder #(.SYNC_STAGES(2)) dut (
      .cpu_clock(cpu_clock), .reset(reset), .bdir(bdir), .bc1(bc1), .da_in(da_in),
      .da_out(da_out), .da_oe(da_oe), .active_chip(active_chip), .addr_valid(addr_valid),
      .wr_stb(wr_stb), .wr_chip(wr_chip), .wr_addr(wr_addr), .wr_data(wr_data),
      .env_restart(env_restart), .regs_flat(regs_flat)
   );

   always #5 cpu_clock = ~cpu_clock;

   typedef struct packed {
      logic       chip;
      logic [3:0] addr;
      logic [7:0] data;
      logic       env;
   } wr_t;

   int           total = 0;
   int           bad = 0;
   int           env_count = 0;
   wr_t          wr_q[$];
   logic [7:0]   rd_q[$];
   logic [255:0] exp_regs = '0;
   logic         prev_oe = 1'b0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe or read-enable rise consumes one expected entry.
   always @(negedge cpu_clock) begin
      if (env_restart) env_count++;
      if (wr_stb) begin
         if (wr_q.size() == 0) check("unexpected wr_stb", 256'(wr_stb), 256'(0));
         else check("write strobe", 256'({wr_chip, wr_addr, wr_data, env_restart}), 256'(wr_q.pop_front()));
      end else if (env_restart) begin
         check("env_restart without wr_stb", 256'(env_restart), 256'(0));
      end
      if (da_oe && !prev_oe) begin
         if (rd_q.size() == 0) check("unexpected da_oe", 256'(da_oe), 256'(0));
         else check("read data", 256'(da_out), 256'(rd_q.pop_front()));
      end
      prev_oe = da_oe;
   end

   task automatic phase(input logic [1:0] m, input logic [7:0] d, input int n);
      {bdir, bc1} = m;
      da_in = d;
      repeat (n) @(posedge cpu_clock);
      #1;
   endtask

   task automatic do_latch(input logic [7:0] v);
      phase(2'b11, v, 6);
      phase(2'b00, 8'h00, 6);
   endtask

   task automatic do_write(input logic [7:0] v);
      phase(2'b10, v, 6);
      phase(2'b00, 8'h00, 6);
   endtask

   task automatic do_read();
      phase(2'b01, 8'h00, 6);
      phase(2'b00, 8'h00, 6);
   endtask

   task automatic expect_write(input logic chip, input logic [3:0] a, input logic [7:0] d, input logic env);
      wr_q.push_back('{chip: chip, addr: a, data: d, env: env});
      exp_regs[(int'(chip) * 16 + int'(a)) * 8 +: 8] = d;
   endtask

   initial begin
      repeat (3) @(posedge cpu_clock);
      #1;
      check("reset regs_flat", regs_flat, 256'(0));
      check("reset addr_valid", 256'(addr_valid), 256'(1));
      check("reset active_chip", 256'(active_chip), 256'(0));
      check("reset da_oe/da_out", 256'({da_oe, da_out}), 256'(0));
      check("reset wr outputs", 256'({wr_stb, wr_chip, wr_addr, wr_data, env_restart}), 256'(0));
      reset = 1'b1;
      phase(2'b00, 8'h00, 3);

      do_latch(8'h07);
      check("addr_valid after latch 07", 256'(addr_valid), 256'(1));
      expect_write(1'b0, 4'd7, 8'hAA, 1'b0);
      do_write(8'hAA);
      rd_q.push_back(8'hAA);
      do_read();
      check("regs after R7 write", regs_flat, exp_regs);

      do_latch(8'h01);
      expect_write(1'b0, 4'd1, 8'h0F, 1'b0);
      do_write(8'hFF);
      do_latch(8'h0D);
      expect_write(1'b0, 4'd13, 8'h0E, 1'b1);
      do_write(8'h3E);
      check("regs after masked writes", regs_flat, exp_regs);

`ifdef TURBOSOUND_EN
      do_latch(8'hFE);
      check("active_chip after FE", 256'(active_chip), 256'(1));
      do_latch(8'h00);
      expect_write(1'b1, 4'd0, 8'h55, 1'b0);
      do_write(8'h55);
      do_latch(8'hFF);
      check("active_chip after FF", 256'(active_chip), 256'(0));
      check("addr_valid kept after FF", 256'(addr_valid), 256'(1));
      rd_q.push_back(8'h00);
      do_read();
`else
      do_latch(8'hFE);
      check("addr_valid after FE", 256'(addr_valid), 256'(0));
      do_latch(8'h00);
      expect_write(1'b0, 4'd0, 8'h55, 1'b0);
      do_write(8'h55);
      do_latch(8'hFF);
      check("addr_valid after FF", 256'(addr_valid), 256'(0));
      check("active_chip tied", 256'(active_chip), 256'(0));
      do_read();
`endif
      check("regs after chip-select sequence", regs_flat, exp_regs);

      do_latch(8'h17);
      check("addr_valid after 17", 256'(addr_valid), 256'(0));
      do_write(8'h12);
      do_read();
      check("regs unchanged by invalid write", regs_flat, exp_regs);

      do_latch(8'h02);
      phase(2'b00, 8'h00, 2);
      phase(2'b10, 8'h99, 1);
      phase(2'b00, 8'h00, 8);
      check("regs unchanged by glitch", regs_flat, exp_regs);

      do_latch(8'h03);
      phase(2'b10, 8'h44, 5);
      reset = 1'b0;
      phase(2'b00, 8'h00, 2);
      exp_regs = '0;
      check("regs cleared by reset", regs_flat, exp_regs);
      check("addr_valid after mid-write reset", 256'(addr_valid), 256'(1));
      check("wr_stb during reset", 256'({wr_stb, env_restart}), 256'(0));
      reset = 1'b1;
      phase(2'b00, 8'h00, 10);

      do_latch(8'h05);
      expect_write(1'b0, 4'd5, 8'h0C, 1'b0);
      do_write(8'h3C);
      rd_q.push_back(8'h0C);
      do_read();
      check("regs after post-reset write", regs_flat, exp_regs);

      phase(2'b00, 8'h00, 10);
      check("pending writes drained", 256'(wr_q.size()), 256'(0));
      check("pending reads drained", 256'(rd_q.size()), 256'(0));
      check("env_restart pulse count", 256'(env_count), 256'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
